// File: rtl/prio_irq_enc.sv
// prio_irq_enc: registered priority encoder with per-channel pending latches,
// a selection mask and an acknowledge handshake. The highest-numbered unmasked
// pending channel is presented on idx and held there until it is acknowledged.
module prio_irq_enc #(
    parameter int N    = 8,
    parameter bit EDGE = 1'b1,
    localparam int W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] pend
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] req_q;
    logic [N-1:0] set;
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    logic [W-1:0] sel;
    logic         any_elig;
    logic [W-1:0] idx_next;
    logic         valid_next;

    // Masked channels still latch pending; they are only kept out of selection.
    assign elig = pend & ~mask;

    // New requests (edge or level) and the one-hot clear of an accepted channel.
    always_comb begin
        set = EDGE ? (req & ~req_q) : req;
        clr = '0;
        if (valid && ack) begin
            clr[idx] = 1'b1;
        end
    end

    // Upward scan so the highest eligible channel is the last one written.
    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                sel      = W'(i);
                any_elig = 1'b1;
            end
        end
    end

    // Next-state logic: latch a choice when idle, hold it until acknowledged.
    always_comb begin
        state_next = state;
        valid_next = valid;
        idx_next   = idx;
        case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (any_elig) begin
                    idx_next   = sel;
                    valid_next = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers; a fresh set beats a same-cycle clear on the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            pend  <= '0;
            valid <= 1'b0;
            idx   <= '0;
        end else begin
            req_q <= req;
            pend  <= (pend & ~clr) | set;
            valid <= valid_next;
            idx   <= idx_next;
        end
    end

endmodule

// File: tb/tb_prio_irq_enc.sv
// tb_prio_irq_enc: table-driven directed vectors, hand-written corner
// sequences and a randomized run against a behavioural model, covering both
// the edge-triggered and the level-triggered configuration.
module tb_prio_irq_enc;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;

    logic       validE;
    logic [2:0] idxE;
    logic [7:0] pendE;
    logic       validL;
    logic [2:0] idxL;
    logic [7:0] pendL;

    int checks;
    int passes;

    typedef struct packed {
        logic [7:0] pend;
        logic [7:0] prevReq;
        logic       presenting;
        logic [2:0] idx;
    } model_t;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic       expValid;
        logic [2:0] expIdx;
        logic [7:0] expPend;
    } vec_t;

    model_t modelE;
    model_t modelL;
    vec_t   vecs[$];

    prio_irq_enc #(.N(8), .EDGE(1'b1)) dutEdge (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .mask (mask),
        .ack  (ack),
        .valid(validE),
        .idx  (idxE),
        .pend (pendE)
    );

    prio_irq_enc #(.N(8), .EDGE(1'b0)) dutLevel (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .mask (mask),
        .ack  (ack),
        .valid(validL),
        .idx  (idxL),
        .pend (pendL)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: one clock of the request selector.
    function automatic model_t modelStep(model_t m, bit edgeMode, logic [7:0] r,
                                         logic [7:0] mk, logic a);
        model_t n;
        int     best;
        bit     fired;
        bit     taken;
        n    = m;
        best = -1;
        for (int ch = 0; ch < 8; ch++) begin
            fired = edgeMode ? (r[ch] && !m.prevReq[ch]) : bit'(r[ch]);
            taken = m.presenting && a && (int'(m.idx) == ch);
            n.pend[ch] = (m.pend[ch] && !taken) || fired;
            if (m.pend[ch] && !mk[ch]) best = ch;
        end
        n.prevReq = r;
        if (m.presenting) begin
            if (a) n.presenting = 1'b0;
        end else if (best >= 0) begin
            n.presenting = 1'b1;
            n.idx        = 3'(best);
        end
        return n;
    endfunction

    function automatic vec_t mkVec(logic [7:0] r, logic [7:0] mk, logic a,
                                   logic v, logic [2:0] i, logic [7:0] p);
        vec_t x;
        x.req      = r;
        x.mask     = mk;
        x.ack      = a;
        x.expValid = v;
        x.expIdx   = i;
        x.expPend  = p;
        return x;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive on the falling edge, advance both models at the rising edge, sample just after.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] mk, input logic a);
        @(negedge clk);
        req  = r;
        mask = mk;
        ack  = a;
        @(posedge clk);
        modelE = modelStep(modelE, 1'b1, r, mk, a);
        modelL = modelStep(modelL, 1'b0, r, mk, a);
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = '0;
        mask   = '0;
        ack    = 1'b0;
        modelE = '0;
        modelL = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic compareModels(input int cyc);
        checkOutput($sformatf("rndE%0d_valid", cyc), int'(validE), int'(modelE.presenting));
        checkOutput($sformatf("rndE%0d_idx", cyc), int'(idxE), int'(modelE.idx));
        checkOutput($sformatf("rndE%0d_pend", cyc), int'(pendE), int'(modelE.pend));
        checkOutput($sformatf("rndL%0d_valid", cyc), int'(validL), int'(modelL.presenting));
        checkOutput($sformatf("rndL%0d_idx", cyc), int'(idxL), int'(modelL.idx));
        checkOutput($sformatf("rndL%0d_pend", cyc), int'(pendL), int'(modelL.pend));
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        req    = '0;
        mask   = '0;
        ack    = 1'b0;
        modelE = '0;
        modelL = '0;

        // Directed vectors for the edge-triggered instance, starting from reset.
        // Single pulse on channel 5, then acknowledge.
        vecs.push_back(mkVec(8'h20, 8'h00, 1'b0, 1'b0, 3'd0, 8'h20));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h20));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b0, 3'd5, 8'h00));
        // Three simultaneous requests drain 7, 3, 1 with a gap between each.
        vecs.push_back(mkVec(8'h8A, 8'h00, 1'b0, 1'b0, 3'd5, 8'h8A));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd7, 8'h8A));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h0A));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h0A));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd3, 8'h02));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd1, 8'h02));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00));
        // Ack while idle changes nothing.
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00));
        // No pre-emption: channel 6 arrives while 2 is presented.
        vecs.push_back(mkVec(8'h04, 8'h00, 1'b0, 1'b0, 3'd1, 8'h04));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04));
        vecs.push_back(mkVec(8'h40, 8'h00, 1'b0, 1'b1, 3'd2, 8'h44));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h44));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h40));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd6, 8'h40));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00));
        // Masked channel 7 is held, then presented once unmasked; late mask does not pull it.
        vecs.push_back(mkVec(8'h90, 8'h80, 1'b0, 1'b0, 3'd6, 8'h90));
        vecs.push_back(mkVec(8'h00, 8'h80, 1'b0, 1'b1, 3'd4, 8'h90));
        vecs.push_back(mkVec(8'h00, 8'h80, 1'b1, 1'b0, 3'd4, 8'h80));
        vecs.push_back(mkVec(8'h00, 8'h80, 1'b0, 1'b0, 3'd4, 8'h80));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80));
        vecs.push_back(mkVec(8'h00, 8'h80, 1'b0, 1'b1, 3'd7, 8'h80));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00));
        // A new rising edge in the ack cycle re-arms the same channel.
        vecs.push_back(mkVec(8'h08, 8'h00, 1'b0, 1'b0, 3'd7, 8'h08));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08));
        vecs.push_back(mkVec(8'h08, 8'h00, 1'b1, 1'b0, 3'd3, 8'h08));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08));
        vecs.push_back(mkVec(8'h00, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00));

        #12;
        checkOutput("reset_valid", int'(validE), 0);
        checkOutput("reset_idx", int'(idxE), 0);
        checkOutput("reset_pend", int'(pendE), 0);
        checkOutput("reset_validL", int'(validL), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].mask, vecs[i].ack);
            checkOutput($sformatf("vec%0d_valid", i), int'(validE), int'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_idx", i), int'(idxE), int'(vecs[i].expIdx));
            checkOutput($sformatf("vec%0d_pend", i), int'(pendE), int'(vecs[i].expPend));
        end

        // Level mode: a held request is re-presented after every ack, then stops on release.
        applyReset();
        applyStimulus(8'h08, 8'h00, 1'b0);
        checkOutput("lvl_pend_set", int'(pendL), 8'h08);
        checkOutput("lvl_wait", int'(validL), 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'h08, 8'h00, 1'b0);
            checkOutput($sformatf("lvl_pres%0d_valid", k), int'(validL), 1);
            checkOutput($sformatf("lvl_pres%0d_idx", k), int'(idxL), 3);
            applyStimulus(8'h08, 8'h00, 1'b1);
            checkOutput($sformatf("lvl_ack%0d_valid", k), int'(validL), 0);
            checkOutput($sformatf("lvl_ack%0d_pend", k), int'(pendL), 8'h08);
        end
        applyStimulus(8'h08, 8'h00, 1'b0);
        checkOutput("lvl_last_valid", int'(validL), 1);
        applyStimulus(8'h00, 8'h00, 1'b1);
        checkOutput("lvl_release_pend", int'(pendL), 0);
        checkOutput("lvl_release_valid", int'(validL), 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'h00, 8'h00, 1'b0);
            checkOutput($sformatf("lvl_quiet%0d", k), int'(validL), 0);
        end

        // Asynchronous reset while presenting channel 5 with channel 2 also pending.
        applyReset();
        applyStimulus(8'h24, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0);
        checkOutput("arst_pre_valid", int'(validE), 1);
        checkOutput("arst_pre_idx", int'(idxE), 5);
        checkOutput("arst_pre_pend", int'(pendE), 8'h24);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", int'(validE), 0);
        checkOutput("arst_pend", int'(pendE), 0);
        modelE = '0;
        modelL = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'h00, 8'h00, 1'b0);
            checkOutput($sformatf("arst_quiet%0d", k), int'(validE), 0);
        end

        // Randomized traffic on both instances against the model.
        applyReset();
        for (int c = 0; c < 300; c++) begin
            logic [7:0] r;
            logic [7:0] mk;
            r  = 8'($urandom & $urandom);
            mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            applyStimulus(r, mk, 1'($urandom_range(0, 1)));
            compareModels(c);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
